// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - 1 KiB data memory with fixed-latency request/stall/ready handshake
module data_mem_responder #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        memMemRead,
  input  logic        memMemWrite,
  input  logic [2:0]  memMemMode,
  input  logic [31:0] memALUOut,
  input  logic [31:0] memWriteToMemData,
  output logic        memStall,
  output logic [31:0] memReadData,
  output logic        memReady,
  output logic        memErr
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [2:0] MODE_WORD  = 3'b000;
  localparam logic [2:0] MODE_HALFS = 3'b001;
  localparam logic [2:0] MODE_HALFU = 3'b010;
  localparam logic [2:0] MODE_BYTES = 3'b011;
  localparam logic [2:0] MODE_BYTEU = 3'b100;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic [2:0]  mode_q, mode_d;
  logic [9:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] mem [256];

  // Address bits above the 1 KiB window are deliberately dropped (wrap-around).
  logic unused_addr_hi;
  assign unused_addr_hi = ^memALUOut[31:10];

  logic is_word, is_half, req_any, req_one, bad_req, valid_req, reject_req, commit;
  logic [31:0] word_rd, load_val, store_word, wd_lanes;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [3:0]  byte_en;

  // Classify the incoming request; both strobes high counts as a malformed request.
  always_comb begin
    is_word    = (memMemMode == MODE_WORD);
    is_half    = (memMemMode == MODE_HALFS) || (memMemMode == MODE_HALFU);
    req_any    = memMemRead | memMemWrite;
    req_one    = memMemRead ^ memMemWrite;
    bad_req    = (memMemRead & memMemWrite) || (memMemMode > MODE_BYTEU) ||
                 (is_half && memALUOut[0]) || (is_word && (memALUOut[1:0] != 2'b00));
    valid_req  = req_one & ~bad_req;
    reject_req = req_any & bad_req;
    commit     = (state_q == BUSY) && (cnt_q == 4'd0);
  end

  // Lane selection and extension for loads, lane merge for stores, using the latched request.
  always_comb begin
    word_rd  = mem[addr_q[9:2]];
    half_sel = addr_q[1] ? word_rd[31:16] : word_rd[15:0];
    case (addr_q[1:0])
      2'd0:    byte_sel = word_rd[7:0];
      2'd1:    byte_sel = word_rd[15:8];
      2'd2:    byte_sel = word_rd[23:16];
      default: byte_sel = word_rd[31:24];
    endcase
    case (mode_q)
      MODE_HALFS: load_val = {{16{half_sel[15]}}, half_sel};
      MODE_HALFU: load_val = {16'h0000, half_sel};
      MODE_BYTES: load_val = {{24{byte_sel[7]}}, byte_sel};
      MODE_BYTEU: load_val = {24'h000000, byte_sel};
      default:    load_val = word_rd;
    endcase
    case (mode_q)
      MODE_HALFS, MODE_HALFU: begin
        byte_en  = addr_q[1] ? 4'b1100 : 4'b0011;
        wd_lanes = {2{wdata_q[15:0]}};
      end
      MODE_BYTES, MODE_BYTEU: begin
        byte_en  = 4'b0001 << addr_q[1:0];
        wd_lanes = {4{wdata_q[7:0]}};
      end
      default: begin
        byte_en  = 4'b1111;
        wd_lanes = wdata_q;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      store_word[i*8 +: 8] = byte_en[i] ? wd_lanes[i*8 +: 8] : word_rd[i*8 +: 8];
    end
  end

  // Next-state and output logic; the request is captured on acceptance so BUSY ignores input changes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    we_d     = we_q;
    mode_d   = mode_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    memStall = 1'b0;
    case (state_q)
      IDLE: begin
        if (reject_req) begin
          err_d = 1'b1;
        end else if (valid_req) begin
          memStall = 1'b1;
          cnt_d    = 4'(LATENCY - 1);
          state_d  = BUSY;
          we_d     = memMemWrite;
          mode_d   = memMemMode;
          addr_d   = memALUOut[9:0];
          wdata_d  = memWriteToMemData;
        end
      end
      BUSY: begin
        memStall = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          ready_d = 1'b1;
          if (!we_q) rdata_d = load_val;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control/status registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      mode_q  <= MODE_WORD;
      addr_q  <= 10'h000;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      we_q    <= we_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Storage array is never cleared; a reset on the commit edge suppresses the store.
  always_ff @(posedge clk) begin
    if (resetn && commit && we_q) begin
      mem[addr_q[9:2]] <= store_word;
    end
  end

  assign memReadData = rdata_q;
  assign memReady    = ready_q;
  assign memErr      = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed scoreboard bench for data_mem_responder
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        memMemRead, memMemWrite;
  logic [2:0]  memMemMode;
  logic [31:0] memALUOut, memWriteToMemData;
  logic        memStall, memReady, memErr;
  logic [31:0] memReadData;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;

  data_mem_responder #(.LATENCY(LAT)) dut (
    .clk(clk),
    .resetn(resetn),
    .memMemRead(memMemRead),
    .memMemWrite(memMemWrite),
    .memMemMode(memMemMode),
    .memALUOut(memALUOut),
    .memWriteToMemData(memWriteToMemData),
    .memStall(memStall),
    .memReadData(memReadData),
    .memReady(memReady),
    .memErr(memErr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    memMemRead        = 1'b0;
    memMemWrite       = 1'b0;
    memMemMode        = 3'b000;
    memALUOut         = 32'h0;
    memWriteToMemData = 32'h0;
  endtask

  task automatic do_access(input string tag, input bit is_wr, input logic [2:0] mode,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] exp);
    int cyc;
    int stall_cnt;
    logic [31:0] want;
    memMemRead        = !is_wr;
    memMemWrite       = is_wr;
    memMemMode        = mode;
    memALUOut         = addr;
    memWriteToMemData = data;
    if (!is_wr) exp_q.push_back(exp);
    #1;
    check({tag, "_stall_c0"}, 32'(memStall), 32'd1);
    stall_cnt = 1;
    @(posedge clk); #1;
    cyc = 1;
    memMemRead        = is_wr;
    memMemWrite       = !is_wr;
    memMemMode        = 3'b111;
    memALUOut         = 32'hFFFF_FFFF;
    memWriteToMemData = 32'h5A5A_5A5A;
    while (!memReady && cyc < 20) begin
      if (memStall) stall_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_ready_seen"}, 32'(memReady), 32'd1);
    check({tag, "_ready_cycle"}, 32'(cyc), 32'(LAT + 1));
    check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(LAT + 1));
    check({tag, "_stall_done"}, 32'(memStall), 32'd0);
    if (!is_wr) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s_scoreboard_empty observed=empty expected=entry", tag);
      end else begin
        want = exp_q.pop_front();
        check({tag, "_rdata"}, memReadData, want);
        last_rd = want;
      end
    end else begin
      check({tag, "_rdata_kept"}, memReadData, last_rd);
    end
    idle_inputs();
    @(posedge clk); #1;
    check({tag, "_ready_drop"}, 32'(memReady), 32'd0);
    check({tag, "_idle_stall"}, 32'(memStall), 32'd0);
  endtask

  task automatic do_err(input string tag, input logic rd, input logic wr, input logic [2:0] mode,
                        input logic [31:0] addr, input logic [31:0] data);
    memMemRead        = rd;
    memMemWrite       = wr;
    memMemMode        = mode;
    memALUOut         = addr;
    memWriteToMemData = data;
    #1;
    check({tag, "_stall"}, 32'(memStall), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    check({tag, "_err"}, 32'(memErr), 32'd1);
    check({tag, "_ready"}, 32'(memReady), 32'd0);
    check({tag, "_stall_after"}, 32'(memStall), 32'd0);
    @(posedge clk); #1;
    check({tag, "_err_drop"}, 32'(memErr), 32'd0);
  endtask

  initial begin
    logic ready_seen;
    resetn = 1'b0;
    idle_inputs();
    last_rd = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", memReadData, 32'h0);
    check("rst_ready", 32'(memReady), 32'd0);
    check("rst_err", 32'(memErr), 32'd0);
    check("rst_stall", 32'(memStall), 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    do_access("st_w10", 1'b1, 3'b000, 32'h10, 32'hDEAD_BEEF, 32'h0);
    do_access("ld_w10", 1'b0, 3'b000, 32'h10, 32'h0, 32'hDEAD_BEEF);

    do_access("st_w10_clr", 1'b1, 3'b000, 32'h10, 32'h0, 32'h0);
    do_access("st_b13", 1'b1, 3'b011, 32'h13, 32'hAAAA_AA80, 32'h0);
    do_access("ld_bs13", 1'b0, 3'b011, 32'h13, 32'h0, 32'hFFFF_FF80);
    do_access("ld_bu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_0080);
    do_access("ld_w10b", 1'b0, 3'b000, 32'h10, 32'h0, 32'h8000_0000);
    do_access("st_b11", 1'b1, 3'b100, 32'h11, 32'h1234_567F, 32'h0);
    do_access("ld_bs11", 1'b0, 3'b011, 32'h11, 32'h0, 32'h0000_007F);
    do_access("ld_w10c", 1'b0, 3'b000, 32'h10, 32'h0, 32'h8000_7F00);

    do_access("st_w20_clr", 1'b1, 3'b000, 32'h20, 32'h0, 32'h0);
    do_access("st_h22", 1'b1, 3'b001, 32'h22, 32'h5555_1234, 32'h0);
    do_access("ld_hs22", 1'b0, 3'b001, 32'h22, 32'h0, 32'h0000_1234);
    do_access("ld_w20", 1'b0, 3'b000, 32'h20, 32'h0, 32'h1234_0000);
    do_access("st_h20", 1'b1, 3'b010, 32'h20, 32'hFFFF_8001, 32'h0);
    do_access("ld_hs20", 1'b0, 3'b001, 32'h20, 32'h0, 32'hFFFF_8001);
    do_access("ld_hu20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h0000_8001);

    do_err("err_ldw11", 1'b1, 1'b0, 3'b000, 32'h11, 32'h0);
    do_err("err_ldh21", 1'b1, 1'b0, 3'b001, 32'h21, 32'h0);
    do_err("err_mode5", 1'b1, 1'b0, 3'b101, 32'h10, 32'h0);
    do_err("err_rdwr", 1'b1, 1'b1, 3'b000, 32'h10, 32'hFFFF_FFFF);
    do_err("err_stw12", 1'b0, 1'b1, 3'b000, 32'h12, 32'hFFFF_FFFF);
    do_err("err_sth23", 1'b0, 1'b1, 3'b010, 32'h23, 32'hFFFF_FFFF);
    do_access("ld_w10_kept", 1'b0, 3'b000, 32'h10, 32'h0, 32'h8000_7F00);
    do_access("ld_w20_kept", 1'b0, 3'b000, 32'h20, 32'h0, 32'h1234_8001);

    do_access("st_w40", 1'b1, 3'b000, 32'h40, 32'h1111_1111, 32'h0);
    memMemRead        = 1'b0;
    memMemWrite       = 1'b1;
    memMemMode        = 3'b000;
    memALUOut         = 32'h40;
    memWriteToMemData = 32'hCAFE_F00D;
    @(posedge clk); #1;
    check("abort_busy_stall", 32'(memStall), 32'd1);
    resetn = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    check("abort_stall", 32'(memStall), 32'd0);
    check("abort_ready", 32'(memReady), 32'd0);
    check("abort_rdata", memReadData, 32'h0);
    last_rd = 32'h0;
    resetn = 1'b1;
    ready_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      ready_seen = ready_seen | memReady;
    end
    check("abort_no_ready", 32'(ready_seen), 32'd0);
    do_access("ld_w40", 1'b0, 3'b000, 32'h40, 32'h0, 32'h1111_1111);

    do_access("st_w404", 1'b1, 3'b000, 32'h404, 32'h0BAD_F00D, 32'h0);
    do_access("ld_w004", 1'b0, 3'b000, 32'h004, 32'h0, 32'h0BAD_F00D);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning BUSY wait cycles per access; legal range 1..8.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1, meaning reset; it is synchronous and active-low.
REQ-004 SHALL have port memMemRead, input, 1, meaning load request from the MEM stage register.
REQ-005 SHALL have port memMemWrite, input, 1, meaning store request from the MEM stage register.
REQ-006 SHALL have port memMemMode, input, 3, meaning access size/sign: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101-111 illegal.
REQ-007 SHALL have port memALUOut, input, 32, meaning byte address.
REQ-008 SHALL have port memWriteToMemData, input, 32, meaning store data; the low bits supply the half or byte.
REQ-009 SHALL have port memStall, output, 1, meaning the pipeline must hold the MEM stage register.
REQ-010 SHALL have port memReadData, output, 32, meaning load result, extended per mode.
REQ-011 SHALL have port memReady, output, 1, meaning one-cycle pulse marking completion; memReadData is valid in that cycle.
REQ-012 SHALL have port memErr, output, 1, meaning one-cycle pulse on a rejected request.

Function
REQ-013 SHALL hold 256 x 32-bit words (1 KiB), little-endian, indexed by memALUOut[9:2]; address bits [31:10] are ignored, so addresses wrap modulo 1 KiB.
REQ-014 SHALL implement FSM states IDLE, BUSY and DONE, with a wait counter 4 bits wide.
REQ-015 SHALL treat a request as memMemRead XOR memMemWrite; when both inputs are low, the block stays in IDLE with all outputs idle.
REQ-016 SHALL reject a request in IDLE when any of the following holds: both memMemRead and memMemWrite are high; the mode is illegal; a half access has addr[0]=1; a word access has addr[1:0]!=0.
REQ-017 SHALL handle a rejected request as follows: memErr=1 for exactly one cycle, no memory access, memStall=0, memReady=0, remain IDLE.
REQ-018 SHALL, on a valid request in IDLE, load the counter with LATENCY-1 and go to BUSY.
REQ-019 SHALL, in BUSY, decrement the counter each cycle; on the edge where the counter equals 0, perform the access and go to DONE.
REQ-020 SHALL perform stores as follows: word writes all 4 lanes; half writes the lanes selected by addr[1] with data[15:0]; byte writes the lane selected by addr[1:0] with data[7:0]; other lanes are unchanged.
REQ-021 SHALL perform loads as follows: select the lane(s) as in REQ-020 and zero- or sign-extend to 32 bits per mode, registering the result into memReadData on the same edge; stores leave memReadData unchanged.
REQ-022 SHALL, in DONE, drive memReady=1 for one cycle and then go to IDLE unconditionally.
REQ-023 SHALL drive memStall combinationally: 1 when (state=IDLE and valid request) or state=BUSY; 0 in DONE and for rejected requests.
REQ-024 SHALL have this timing: request visible in cycle 0; memStall high in cycles 0..LATENCY; memReady in cycle LATENCY+1; total LATENCY+2 cycles per access.
REQ-025 SHALL, in IDLE after DONE, evaluate the newly presented request normally, so back-to-back accesses leave no extra bubble beyond REQ-024.
REQ-026 SHALL ignore changes to the request inputs while in BUSY; the pipeline holds them stable by contract.

Reset
REQ-027 SHALL, when resetn=0 at a rising edge, set state=IDLE, counter=0, memReadData=0, memReady=0 and memErr=0; memStall then follows REQ-023.
REQ-028 SHALL, on a reset that occurs while in BUSY before the commit edge, abort the access with no store committed; a reset in DONE loses memReady.
REQ-029 SHALL NOT reset memory array contents.
REQ-030 SHALL give resetn priority over every other event in the same cycle.

Verification
REQ-031 SHALL be verified with: LATENCY=2, word store 0xDEADBEEF @0x10, then word load @0x10 -> memStall high 3 cycles each, memReady in cycle 3, memReadData=0xDEADBEEF.
REQ-032 SHALL be verified with: byte store 0x80 @0x13 over word 0x00000000, then byte-signed load @0x13 -> 0xFFFFFF80; byte-unsigned load -> 0x00000080; word load @0x10 -> 0x80000000.
REQ-033 SHALL be verified with: half store 0x1234 @0x22, then half-signed load @0x22 -> 0x00001234; word load @0x20 -> 0x12340000.
REQ-034 SHALL be verified with: word load @0x11, half load @0x21, mode 101, and read+write both high -> each gives a memErr pulse, memStall=0, memory unchanged.
REQ-035 SHALL be verified with: word store 0xCAFEF00D @0x40 with resetn low in the first BUSY cycle -> state IDLE, memReady never asserted, later load @0x40 returns the prior value.
REQ-036 SHALL be verified with: store @0x404 then load @0x004 -> wrap-around aliasing returns the stored value.
